// File: rtl/simple_fifo_thresh.sv
// Single-clock FIFO with valid/ready on both sides, registered threshold flags and optional output flop.
// Define SIMPLE_FIFO_WATERMARK_EN to build the peak-occupancy (max_count) tracker.
module simple_fifo_thresh #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int OUTPUT_REG = 1,
    parameter int INIT_ZERO  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  din_ready,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  dout_ready,
    input  logic [ADDR_WIDTH:0]   almost_full_thresh,
    input  logic [ADDR_WIDTH:0]   almost_empty_thresh,
    output logic [ADDR_WIDTH:0]   item_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   max_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  enque;
    logic                  deque;
    logic                  rd_adv;
    logic [ADDR_WIDTH:0]   count_next;

    // Handshake: a word transfers on a clock edge where valid & ready are both 1;
    // valid/data hold until the transfer, ready never depends on valid.
    assign din_ready = rst_n & ~full & ~clear;
    assign enque     = din_valid & din_ready;
    assign deque     = dout_valid & dout_ready;

    always_comb begin
        count_next = item_count;
        if (enque && !deque)
            count_next = item_count + CNT_ONE;
        else if (deque && !enque)
            count_next = item_count - CNT_ONE;
    end

    // Flags are derived from count_next so they line up with item_count every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            item_count   <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else if (clear) begin
            item_count   <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            item_count   <= count_next;
            full         <= (count_next == DEPTH_CNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= almost_full_thresh);
            almost_empty <= (count_next <= almost_empty_thresh);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enque)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_adv)
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        end
    end

    generate
        if (INIT_ZERO != 0) begin : g_ram_init
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++)
                        ram[i] <= '0;
                end else if (enque) begin
                    ram[wr_ptr] <= din;
                end
            end
        end else begin : g_ram_plain
            always_ff @(posedge clk) begin
                if (enque)
                    ram[wr_ptr] <= din;
            end
        end
    endgenerate

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic                  stage_valid;
            logic [DATA_WIDTH-1:0] stage_data;
            logic [ADDR_WIDTH:0]   ram_count;

            // The output flop counts toward item_count, so RAM occupancy excludes it.
            assign ram_count = item_count - {{ADDR_WIDTH{1'b0}}, stage_valid};
            assign rd_adv    = (ram_count != '0) & (~stage_valid | deque);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_valid <= 1'b0;
                    stage_data  <= '0;
                end else if (clear) begin
                    stage_valid <= 1'b0;
                end else if (rd_adv) begin
                    stage_valid <= 1'b1;
                    stage_data  <= ram[rd_ptr];
                end else if (deque) begin
                    stage_valid <= 1'b0;
                end
            end

            assign dout_valid = stage_valid;
            assign dout       = stage_data;
        end else begin : g_out_comb
            assign rd_adv     = deque;
            assign dout_valid = ~empty;
            assign dout       = ram[rd_ptr];
        end
    endgenerate

`ifdef SIMPLE_FIFO_WATERMARK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            max_count <= '0;
        else if (clear)
            max_count <= '0;
        else if (item_count > max_count)
            max_count <= item_count;
    end
`else
    assign max_count = '0;
`endif

endmodule

// File: tb/tb_simple_fifo_thresh.sv
// Scoreboard bench for simple_fifo_thresh: one OUTPUT_REG=1 and one OUTPUT_REG=0 instance, depth 8.
module tb_simple_fifo_thresh;
    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;

    logic          clear, din_valid, din_ready, dout_valid, dout_ready;
    logic [DW-1:0] din, dout;
    logic [AW:0]   item_count, max_count;
    logic          full, empty, almost_full, almost_empty;

    logic          clear_b, din_valid_b, din_ready_b, dout_valid_b, dout_ready_b;
    logic [DW-1:0] din_b, dout_b;
    logic [AW:0]   item_count_b, max_count_b;
    logic          full_b, empty_b, almost_full_b, almost_empty_b;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_q_b[$];
    int            n_compared = 0;
    int            n_mismatched = 0;

    always #5 clk = ~clk;

    simple_fifo_thresh #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1), .INIT_ZERO(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .din_valid(din_valid), .din(din), .din_ready(din_ready),
        .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
        .almost_full_thresh(af_thresh), .almost_empty_thresh(ae_thresh),
        .item_count(item_count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .max_count(max_count)
    );

    simple_fifo_thresh #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0), .INIT_ZERO(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_b),
        .din_valid(din_valid_b), .din(din_b), .din_ready(din_ready_b),
        .dout_valid(dout_valid_b), .dout(dout_b), .dout_ready(dout_ready_b),
        .almost_full_thresh(af_thresh), .almost_empty_thresh(ae_thresh),
        .item_count(item_count_b), .full(full_b), .empty(empty_b),
        .almost_full(almost_full_b), .almost_empty(almost_empty_b), .max_count(max_count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_compared++;
        n_mismatched++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Monitors: pop and compare whenever a word leaves either FIFO.
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL dout_a: got %0h with no word expected", dout);
            end else begin
                check("dout_a", dout, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && dout_valid_b && dout_ready_b) begin
            if (exp_q_b.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL dout_b: got %0h with no word expected", dout_b);
            end else begin
                check("dout_b", dout_b, exp_q_b.pop_front());
            end
        end
    end

    task automatic write_word(input logic [DW-1:0] d);
        bit done = 0;
        din_valid = 1'b1;
        din = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (din_ready) begin
                exp_q.push_back(d);
                done = 1;
                break;
            end
        end
        if (!done) timeout_fail("write_word");
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        dout_ready = 1'b1;
        dout_ready_b = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0 && exp_q_b.size() == 0) begin
                done = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) timeout_fail("drain");
        dout_ready = 1'b0;
        dout_ready_b = 1'b0;
    endtask

    task automatic check_flags(input int cnt);
        check("item_count", item_count, cnt);
        check("empty", empty, cnt == 0);
        check("full", full, cnt == DEPTH);
        check("almost_full", almost_full, cnt >= int'(af_thresh));
        check("almost_empty", almost_empty, cnt <= int'(ae_thresh));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, item_count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_almost_full"}, almost_full, 0);
        check({tag, "_almost_empty"}, almost_empty, 1);
        check({tag, "_din_ready"}, din_ready, 0);
        check({tag, "_dout_valid"}, dout_valid, 0);
        check({tag, "_max_count"}, max_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 0; din_valid = 0; din = '0; dout_ready = 0;
        clear_b = 0; din_valid_b = 0; din_b = '0; dout_ready_b = 0;
        af_thresh = 4'd6;
        ae_thresh = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_count_b", item_count_b, 0);
        check("reset_dout_valid_b", dout_valid_b, 0);
        rst_n = 1'b1;

        // Clear with a pending write: contents dropped, watermark reset.
        for (int i = 0; i < 5; i++) write_word(DW'(16'h3000 + i));
        check_flags(5);
`ifdef SIMPLE_FIFO_WATERMARK_EN
        check("max_lag", max_count, 4);
`else
        check("max_lag", max_count, 0);
`endif
        @(posedge clk);
        #1;
`ifdef SIMPLE_FIFO_WATERMARK_EN
        check("max_before_clear", max_count, 5);
`else
        check("max_before_clear", max_count, 0);
`endif
        clear = 1'b1;
        din_valid = 1'b1;
        din = 16'h3777;
        exp_q.delete();
        @(negedge clk);
        check("din_ready_clear", din_ready, 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        din_valid = 1'b0;
        check_flags(0);
        check("clear_dout_valid", dout_valid, 0);
        check("clear_max", max_count, 0);
        write_word(16'h3AAA);
        check_flags(1);
        drain();
        check_flags(0);

        // Fill to full, blocked write, full+deque, then drain; three rounds wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            dout_ready = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                write_word(DW'(r * 16 + i));
                check_flags(i + 1);
                check("din_ready_fill", din_ready, i < DEPTH - 1);
            end
            din_valid = 1'b1;
            din = 16'hFFFF;
            repeat (3) begin
                @(negedge clk);
                check("din_ready_full", din_ready, 0);
            end
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            check_flags(DEPTH);

            din_valid = 1'b1;
            din = DW'(r * 16 + 8);
            dout_ready = 1'b1;
            @(negedge clk);
            check("din_ready_full_deq", din_ready, 0);
            @(posedge clk);
            #1;
            dout_ready = 1'b0;
            check("din_ready_after_deq", din_ready, 1);
            check_flags(DEPTH - 1);
            @(negedge clk);
            if (din_ready) exp_q.push_back(din);
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            check_flags(DEPTH);

            drain();
            check_flags(0);
            check("drain_dout_valid", dout_valid, 0);
        end

        // Streaming on both instances: 1 word/cycle, constant occupancy.
        dout_ready = 1'b1;
        dout_ready_b = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            din_valid = 1'b1;
            din = DW'(16'h1000 + j);
            din_valid_b = 1'b1;
            din_b = DW'(16'h2000 + j);
            @(negedge clk);
            if (din_ready) exp_q.push_back(din);
            if (din_ready_b) exp_q_b.push_back(din_b);
            @(posedge clk);
            #1;
            check("stream_count_a", item_count, (j == 1) ? 1 : 2);
            check("stream_valid_a", dout_valid, j >= 2);
            check("stream_count_b", item_count_b, 1);
            check("stream_valid_b", dout_valid_b, 1);
            check("stream_ready_a", din_ready, 1);
        end
        din_valid = 1'b0;
        din_valid_b = 1'b0;
        check("stream_resid_a", exp_q.size(), 2);
        check("stream_resid_b", exp_q_b.size(), 1);
        drain();
        check_flags(0);
        check("stream_end_count_b", item_count_b, 0);

        // Asynchronous reset in the middle of a stream.
        dout_ready = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            din_valid = 1'b1;
            din = DW'(16'h4000 + j);
            @(negedge clk);
            if (din_ready) exp_q.push_back(din);
            @(posedge clk);
            #1;
        end
        #3;
        rst_n = 1'b0;
        din_valid = 1'b0;
        dout_ready = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        write_word(16'h5A5A);
        check_flags(1);
        drain();
        check_flags(0);

        check("final_queue_a", exp_q.size(), 0);
        check("final_queue_b", exp_q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
